mc10_bus_ctrl: RTL and testbench

//  Parametrised CPU bus controller for the MC-10 family core. It replaces the fixed divider, 74155 decode,
//  U8 output latch and keyboard read buffer with one sequenced bus-cycle engine. Adds configurable RAM

---
 rtl/mc10_bus_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mc10_bus_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc10_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc10_bus_ctrl
// Description : Sequenced bus-cycle engine for the MC-10 6803 core. Each CPU
//               E-cycle is DIV clk_sys clocks long. One access is made per
//               E-cycle to ROM, dual-port RAM, the keyboard/output-latch I/O
//               page or the expansion connector. Expansion accesses may stall
//               the E-cycle until exp_ready arrives or a wait budget expires.
// Ports       : clk_sys, reset_n          clock, async active-low reset
//               cpu_addr/dout/rw/vma       CPU request (stable between ce)
//               cpu_ce, cpu_din            E-cycle end pulse, registered read data
//               rom_cs, rom_q              ROM select and 1-clk latency data
//               ram_addr, ram_we, ram_q    RAM word address, write strobe, data
//               kb_in                      keyboard rows, active-high pressed
//               exp_sel/din/ready          expansion claim, data, completion
//               exp_req, exp_timeout       expansion busy, timeout pulse
//               io_latch                   VDG mode/CSS/sound output latch
// Revision    : 1.0 - initial release
// ============================================================================
module mc10_bus_ctrl #(
  parameter int DIV          = 4,
  parameter int RAM_KB       = 4,
  parameter int EXP_WAIT_MAX = 15,
  parameter int LATCH_W      = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_dout,
  input  logic               cpu_rw,
  input  logic               cpu_vma,
  output logic               cpu_ce,
  output logic [7:0]         cpu_din,
  output logic               rom_cs,
  output logic [14:0]        ram_addr,
  output logic               ram_we,
  input  logic [7:0]         rom_q,
  input  logic [7:0]         ram_q,
  input  logic [5:0]         kb_in,
  input  logic               exp_sel,
  input  logic [7:0]         exp_din,
  input  logic               exp_ready,
  output logic               exp_req,
  output logic               exp_timeout,
  output logic [LATCH_W-1:0] io_latch
);

  localparam int              PH_W        = $clog2(DIV);
  localparam logic [PH_W-1:0] PH_ACC_LAST = PH_W'(DIV - 2);
  localparam logic [PH_W-1:0] PH_DONE     = PH_W'(DIV - 1);
  localparam logic [15:0]     RAM_END     = (RAM_KB == 20) ? 16'h8FFF : 16'h7FFF;
  // Below 16 KiB the RAM is mirrored across 4000-7FFF; masking the offset folds
  // every mirror onto the physical array. 20 KiB is not a power of two, but the
  // decode window already bounds the offset, so no folding is needed there.
  localparam logic [14:0]     RAM_MASK    = (RAM_KB >= 20) ? 15'h7FFF : 15'((RAM_KB * 1024) - 1);
  localparam logic [7:0]      WAIT_LAST   = 8'(EXP_WAIT_MAX - 1);

  typedef enum logic [1:0] {ST_DEC, ST_ACC, ST_WAIT, ST_DONE} state_e;
  typedef enum logic [2:0] {TGT_NONE, TGT_RAM, TGT_IO, TGT_ROM, TGT_EXP} tgt_e;

  state_e               state_q, state_d;
  tgt_e                 tgt_q, tgt_d;
  tgt_e                 tgt_dec;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic                 rd_q, rd_d;
  logic [14:0]          ram_addr_q, ram_addr_d;
  logic [7:0]           wcnt_q, wcnt_d;
  logic [7:0]           din_q, din_d;
  logic [LATCH_W-1:0]   latch_q, latch_d;
  logic                 to_q, to_d;
  logic [14:0]          ram_off;
  logic [7:0]           rd_mux;

  // Only the low 15 bits of (cpu_addr - 4000h) can reach the RAM array.
  assign ram_off = (cpu_addr[14:0] - 15'h4000) & RAM_MASK;

  // Address decode; exp_sel overrides the internal map but not a dead cycle.
  always_comb begin
    tgt_dec = TGT_NONE;
    if (cpu_vma) begin
      if (exp_sel)                                          tgt_dec = TGT_EXP;
      else if (cpu_addr >= 16'hC000)                        tgt_dec = TGT_ROM;
      else if (cpu_addr >= 16'hBF00)                        tgt_dec = TGT_IO;
      else if (cpu_addr >= 16'h4000 && cpu_addr <= RAM_END) tgt_dec = TGT_RAM;
      else if (cpu_addr >= 16'h4000)                        tgt_dec = TGT_EXP;
    end
  end

  // Internal read-data sources; writes and unmapped reads return FF.
  always_comb begin
    rd_mux = 8'hFF;
    if (rd_q) begin
      case (tgt_q)
        TGT_RAM: rd_mux = ram_q;
        TGT_ROM: rd_mux = rom_q;
        TGT_IO:  rd_mux = {2'b11, ~kb_in};
        default: rd_mux = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_DEC;
      ph_q       <= '0;
      tgt_q      <= TGT_NONE;
      rd_q       <= 1'b1;
      ram_addr_q <= '0;
      wcnt_q     <= '0;
      din_q      <= 8'hFF;
      latch_q    <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      tgt_q      <= tgt_d;
      rd_q       <= rd_d;
      ram_addr_q <= ram_addr_d;
      wcnt_q     <= wcnt_d;
      din_q      <= din_d;
      latch_q    <= latch_d;
      to_q       <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    tgt_d      = tgt_q;
    rd_d       = rd_q;
    ram_addr_d = ram_addr_q;
    wcnt_d     = wcnt_q;
    din_d      = din_q;
    latch_d    = latch_q;
    to_d       = 1'b0;
    case (state_q)
      ST_DEC: begin
        tgt_d   = tgt_dec;
        rd_d    = cpu_rw;
        wcnt_d  = '0;
        if (tgt_dec == TGT_RAM) ram_addr_d = ram_off;
        ph_d    = PH_W'(1);
        state_d = ST_ACC;
      end
      ST_ACC: begin
        if (ph_q != PH_ACC_LAST) begin
          ph_d = ph_q + PH_W'(1);
        end else if (tgt_q == TGT_EXP) begin
          // A device that is already ready costs no stall at all.
          if (exp_ready) begin
            din_d   = rd_q ? exp_din : 8'hFF;
            ph_d    = PH_DONE;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          din_d = rd_mux;
          if (tgt_q == TGT_IO && !rd_q) latch_d = cpu_dout[7 -: LATCH_W];
          ph_d    = PH_DONE;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        // Phase stays frozen at DIV-2; a late ready still wins on the last stall.
        if (exp_ready) begin
          din_d   = rd_q ? exp_din : 8'hFF;
          ph_d    = PH_DONE;
          state_d = ST_DONE;
        end else if (wcnt_q == WAIT_LAST) begin
          din_d   = 8'hFF;
          to_d    = 1'b1;
          ph_d    = PH_DONE;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        ph_d    = '0;
        state_d = ST_DEC;
      end
      default: begin
        ph_d    = '0;
        state_d = ST_DEC;
      end
    endcase
  end

  assign cpu_ce      = (state_q == ST_DONE) && (ph_q == PH_DONE);
  assign rom_cs      = (state_q == ST_ACC) && (tgt_q == TGT_ROM);
  assign ram_we      = (state_q == ST_ACC) && (ph_q == PH_ACC_LAST) && (tgt_q == TGT_RAM) && !rd_q;
  assign exp_req     = ((state_q == ST_ACC) || (state_q == ST_WAIT)) && (tgt_q == TGT_EXP);
  assign exp_timeout = to_q;
  assign ram_addr    = ram_addr_q;
  assign cpu_din     = din_q;
  assign io_latch    = latch_q;

endmodule
`default_nettype wire

// File: tb/tb_mc10_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc10_bus_ctrl
// Description : Self-checking bench for mc10_bus_ctrl. Provides ROM/RAM
//               devices, drives directed and random E-cycles, and compares
//               every clock against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc10_bus_ctrl;

  localparam int DIV          = 4;
  localparam int RAM_KB       = 4;
  localparam int EXP_WAIT_MAX = 15;
  localparam int LATCH_W      = 6;
  localparam int RAM_TOP      = (RAM_KB == 20) ? 'h8FFF : 'h7FFF;
  localparam int T_NONE = 0, T_RAM = 1, T_IO = 2, T_ROM = 3, T_EXP = 4;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [15:0]        cpu_addr;
  logic [7:0]         cpu_dout;
  logic               cpu_rw, cpu_vma;
  logic               cpu_ce;
  logic [7:0]         cpu_din;
  logic               rom_cs;
  logic [14:0]        ram_addr;
  logic               ram_we;
  logic [7:0]         rom_q, ram_q;
  logic [5:0]         kb_in;
  logic               exp_sel;
  logic [7:0]         exp_din;
  logic               exp_ready;
  logic               exp_req, exp_timeout;
  logic [LATCH_W-1:0] io_latch;

  int n_cmp = 0;
  int n_bad = 0;

  mc10_bus_ctrl #(.DIV(DIV), .RAM_KB(RAM_KB), .EXP_WAIT_MAX(EXP_WAIT_MAX), .LATCH_W(LATCH_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_rw(cpu_rw), .cpu_vma(cpu_vma), .cpu_ce(cpu_ce), .cpu_din(cpu_din),
    .rom_cs(rom_cs), .ram_addr(ram_addr), .ram_we(ram_we), .rom_q(rom_q), .ram_q(ram_q),
    .kb_in(kb_in), .exp_sel(exp_sel), .exp_din(exp_din), .exp_ready(exp_ready),
    .exp_req(exp_req), .exp_timeout(exp_timeout), .io_latch(io_latch)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  // ROM addressed by the CPU bus, RAM by ram_addr; both with 1-clk latency.
  logic [7:0] ram_mem [0:32767];
  always @(posedge clk_sys) begin
    if (ram_we) ram_mem[ram_addr] <= cpu_dout;
    ram_q <= ram_mem[ram_addr];
    rom_q <= rom_cs ? rom_fn(cpu_addr) : 8'h00;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, want, $time);
    end
  endtask

  // Per-clock expectations, written by the driver, checked mid-cycle.
  logic               chk_en = 1'b0;
  logic               e_ce, e_we, e_rom, e_req, e_to;
  logic [7:0]         e_din;
  logic [LATCH_W-1:0] e_latch;
  logic [14:0]        e_waddr;

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("cpu_ce", cpu_ce, e_ce);
      check("ram_we", ram_we, e_we);
      check("rom_cs", rom_cs, e_rom);
      check("exp_req", exp_req, e_req);
      check("exp_timeout", exp_timeout, e_to);
      check("cpu_din", cpu_din, e_din);
      check("io_latch", io_latch, e_latch);
      if (e_we) check("ram_addr", ram_addr, e_waddr);
    end
  end

  // E-cycle length and timeout-pulse monitor for literal checks.
  int ce_cnt = 0, ce_len = 0, to_cnt = 0;
  always @(negedge clk_sys) begin
    if (!reset_n) ce_cnt = 0;
    else begin
      ce_cnt++;
      if (exp_timeout) to_cnt++;
      if (cpu_ce) begin
        ce_len = ce_cnt;
        ce_cnt = 0;
      end
    end
  end

  // Reference model state.
  logic [7:0]         shadow [int];
  logic [7:0]         cur_din;
  logic [LATCH_W-1:0] cur_latch;

  function automatic int tgt_of(input logic [15:0] a, input logic vma, input logic esel);
    if (!vma)              return T_NONE;
    if (esel)              return T_EXP;
    if (a < 16'h4000)      return T_NONE;
    if (a >= 16'hC000)     return T_ROM;
    if (a >= 16'hBF00)     return T_IO;
    if (int'(a) <= RAM_TOP) return T_RAM;
    return T_EXP;
  endfunction

  function automatic int ram_off(input logic [15:0] a);
    int off = int'(a) - 'h4000;
    if (RAM_KB < 16) off = off % (RAM_KB * 1024);
    return off;
  endfunction

  // One E-cycle. Entered just after the edge that starts its decode clock.
  // d = clocks after the first access clock before exp_ready rises.
  task automatic run_txn(input logic [15:0] addr, input logic [7:0] dout, input logic rw,
                         input logic vma, input logic esel, input logic [5:0] kb,
                         input logic [7:0] exdin, input int d, input int abort_at);
    int tgt, w, L, moff;
    bit to;
    logic [7:0] nd;
    logic [LATCH_W-1:0] nl;
    tgt  = tgt_of(addr, vma, esel);
    moff = ram_off(addr);
    w = 0; to = 0;
    if (tgt == T_EXP) begin
      w = d - DIV + 3;
      if (w < 0) w = 0;
      if (w > EXP_WAIT_MAX) begin w = EXP_WAIT_MAX; to = 1; end
    end
    L  = DIV + w;
    nd = 8'hFF;
    nl = cur_latch;
    if (rw) begin
      case (tgt)
        T_RAM:   nd = shadow.exists(moff) ? shadow[moff] : 8'h00;
        T_IO:    nd = {2'b11, ~kb};
        T_ROM:   nd = rom_fn(addr);
        T_EXP:   nd = to ? 8'hFF : exdin;
        default: nd = 8'hFF;
      endcase
    end else begin
      if (tgt == T_IO)  nl = dout[7:8-LATCH_W];
      if (tgt == T_RAM) shadow[moff] = dout;
    end
    cpu_addr = addr; cpu_dout = dout; cpu_rw = rw; cpu_vma = vma;
    exp_sel = esel; kb_in = kb; exp_din = exdin;
    for (int j = 0; j < L; j++) begin
      exp_ready = (j >= 1) && (j - 1 >= d);
      e_ce    = (j == L - 1);
      e_we    = (tgt == T_RAM) && !rw && (j == DIV - 2);
      e_waddr = 15'(moff);
      e_rom   = (tgt == T_ROM) && (j >= 1) && (j <= L - 2);
      e_req   = (tgt == T_EXP) && (j >= 1) && (j <= L - 2);
      e_to    = to && (j == L - 1);
      e_din   = (j == L - 1) ? nd : cur_din;
      e_latch = (j == L - 1) ? nl : cur_latch;
      if (j == abort_at) begin
        chk_en = 1'b0;
        check("pre_abort_exp_req", exp_req, 1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_exp_req", exp_req, 0);
        check("abort_cpu_ce", cpu_ce, 0);
        check("abort_cpu_din", cpu_din, 8'hFF);
        repeat (3) begin
          @(negedge clk_sys);
          check("rst_cpu_ce", cpu_ce, 0);
        end
        @(posedge clk_sys); #1;
        reset_n   = 1'b1;
        cur_din   = 8'hFF;
        cur_latch = '0;
        chk_en    = 1'b1;
        return;
      end
      @(posedge clk_sys); #1;
    end
    cur_din   = nd;
    cur_latch = nl;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int to_before;
    reset_n = 1'b0;
    cpu_addr = '0; cpu_dout = '0; cpu_rw = 1'b1; cpu_vma = 1'b0;
    kb_in = '0; exp_sel = 1'b0; exp_din = '0; exp_ready = 1'b0;
    for (int i = 0; i < 32768; i++) ram_mem[i] = 8'h00;
    repeat (3) @(negedge clk_sys);
    check("rst_cpu_din", cpu_din, 8'hFF);
    check("rst_io_latch", io_latch, 0);
    check("rst_cpu_ce", cpu_ce, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_rom_cs", rom_cs, 0);
    check("rst_exp_req", exp_req, 0);
    check("rst_exp_timeout", exp_timeout, 0);
    check("rst_ram_addr", ram_addr, 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1; cur_din = 8'hFF; cur_latch = '0; chk_en = 1'b1;

    // Idle bus.
    repeat (3) run_txn(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 0, -1);
    check("idle_len", ce_len, 4);
    check("idle_din", cpu_din, 8'hFF);

    // RAM write, read back, mirror.
    run_txn(16'h4123, 8'hA5, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 0, -1);
    run_txn(16'h4123, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 8'h00, 0, -1);
    check("ram_rd_A5", cpu_din, 8'hA5);
    run_txn(16'h5123, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 8'h00, 0, -1);
    check("ram_mirror_A5", cpu_din, 8'hA5);

    // I/O latch and keyboard.
    run_txn(16'hBFFF, 8'hFC, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 0, -1);
    check("io_latch_3F", io_latch, 6'h3F);
    run_txn(16'hBFFF, 8'h00, 1'b1, 1'b1, 1'b0, 6'h01, 8'h00, 0, -1);
    check("kb_rd_FE", cpu_din, 8'hFE);

    // Expansion: three stalls, then timeout, then ready from the start.
    to_before = to_cnt;
    run_txn(16'h9000, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 8'h5A, 4, -1);
    check("exp_rd_5A", cpu_din, 8'h5A);
    check("exp_len_7", ce_len, 7);
    check("exp_no_timeout", to_cnt - to_before, 0);
    run_txn(16'h9000, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 8'h77, 255, -1);
    check("exp_to_din_FF", cpu_din, 8'hFF);
    check("exp_to_len_19", ce_len, 19);
    check("exp_to_pulse", to_cnt - to_before, 1);
    run_txn(16'h9000, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 8'h3C, 0, -1);
    check("exp_ready_early_len", ce_len, 4);

    // exp_sel overrides ROM and RAM; ROM write ignored; ROM read.
    run_txn(16'hC010, 8'h00, 1'b1, 1'b1, 1'b1, 6'h00, 8'h96, 0, -1);
    run_txn(16'h4123, 8'h11, 1'b0, 1'b1, 1'b1, 6'h00, 8'h00, 2, -1);
    run_txn(16'h4123, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 8'h00, 0, -1);
    check("ram_kept_A5", cpu_din, 8'hA5);
    run_txn(16'hD234, 8'h55, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 0, -1);
    run_txn(16'hD234, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 8'h00, 0, -1);
    check("rom_rd", cpu_din, 8'h34 ^ 8'h2D ^ 8'h3C);

    // Reset during a WAIT stall, then resume.
    run_txn(16'h9000, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 8'h00, 255, DIV + 1);
    run_txn(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 0, -1);
    check("resume_len", ce_len, 4);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      int k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: a = 16'h4000 + 16'($urandom_range(0, 3)) * 16'h1000 + 16'($urandom_range(0, 7));
        3:       a = 16'hBF00 | 16'($urandom_range(0, 255));
        4:       a = 16'hC000 + 16'($urandom_range(0, 'h3FFF));
        5:       a = 16'($urandom_range(0, 'h3FFF));
        6:       a = 16'h8000 + 16'($urandom_range(0, 'h3EFF));
        default: a = 16'($urandom_range(0, 'hFFFF));
      endcase
      run_txn(a, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
              6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
              $urandom_range(0, 20), -1);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
